// File: rtl/sign_mag_addsub_pipe.sv
// Two-stage sign-magnitude add/sub/accumulate unit with valid/ready on both sides.
// The S1 register holds the captured operands; the output register holds the result and is backed by acc.

module sm_addsub_core #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] sum,
  output logic         ovf
);
  logic [N-2:0] mx, my, mag;
  logic [N-1:0] mag_w;
  logic         sgn;

  assign mx    = x[N-2:0];
  assign my    = y[N-2:0];
  // Sum of the magnitudes, one bit wider; bit N-1 is the carry that forces saturation
  assign mag_w = {1'b0, mx} + {1'b0, my};

  always_comb begin
    mag = '0;
    sgn = 1'b0;
    ovf = 1'b0;
    if (x[N-1] == y[N-1]) begin
      sgn = x[N-1];
      if (mag_w[N-1]) begin
        mag = '1;
        ovf = 1'b1;
      end else begin
        mag = mag_w[N-2:0];
      end
    end else if (mx >= my) begin
      sgn = x[N-1];
      mag = mx - my;
    end else begin
      sgn = y[N-1];
      mag = my - mx;
    end
    if (mag == '0) sgn = 1'b0;
    sum = {sgn, mag};
  end
endmodule

module sign_mag_addsub_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf
);
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_RDC = 2'b11
  } op_e;

  typedef struct packed {
    op_e          op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } s1_t;

  function automatic logic [N-1:0] pos_zero(input logic [N-1:0] w);
    return (w[N-2:0] == '0) ? '0 : w;
  endfunction

  s1_t          s1_d, s1_q;
  logic         s1_valid;
  logic         out_en, in_accept;
  logic [N-1:0] acc, opnd_y, core_sum, res_sum;
  logic         core_ovf, res_ovf;
  logic [N-1:0] b_flip;

  assign out_en    = !out_valid || out_ready;
  assign in_ready  = !s1_valid || out_en;
  assign in_accept = in_valid && in_ready;

  // Subtract is an add of b with its sign flipped; zero is normalised after the flip
  assign b_flip = in_b ^ {(in_op == OP_SUB), {(N-1){1'b0}}};

  always_comb begin
    s1_d    = '0;
    s1_d.op = op_e'(in_op);
    s1_d.a  = pos_zero(in_a);
    s1_d.b  = pos_zero(b_flip);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_accept) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
    end else if (out_en) begin
      s1_valid <= 1'b0;
    end
  end

  assign opnd_y = (s1_q.op == OP_ACC) ? acc : s1_q.b;

  sm_addsub_core #(.N(N)) u_core (
    .x   (s1_q.a),
    .y   (opnd_y),
    .sum (core_sum),
    .ovf (core_ovf)
  );

  always_comb begin
    res_sum = core_sum;
    res_ovf = core_ovf;
    if (s1_q.op == OP_RDC) begin
      res_sum = acc;
      res_ovf = 1'b0;
    end
  end

  // acc moves on the same edge as the output register so chained accumulates see it next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      acc       <= '0;
    end else if (out_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum <= res_sum;
        out_ovf <= res_ovf;
        case (s1_q.op)
          OP_ACC:  acc <= core_sum;
          OP_RDC:  acc <= '0;
          default: acc <= acc;
        endcase
      end
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid && $stable(out_sum) && $stable(out_ovf));
  a_no_negz: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> out_sum != {1'b1, {(N-1){1'b0}}});
endmodule

// File: tb/tb_sign_mag_addsub_pipe.sv
// Directed and scoreboard-driven checks for sign_mag_addsub_pipe at N=8.
module tb_sign_mag_addsub_pipe;
  localparam int N    = 8;
  localparam int MAXM = (1 << (N-1)) - 1;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [1:0]   in_op;
  logic [N-1:0] in_a, in_b, out_sum;

  typedef struct {
    string      tag;
    logic [N:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_err = 0;
  int   mdl_acc = 0;
  bit   rnd_done = 0;

  sign_mag_addsub_pipe #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N:0] model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int va, vb, r;
    logic o;
    va = a[N-1] ? -int'(a[N-2:0]) : int'(a[N-2:0]);
    vb = b[N-1] ? -int'(b[N-2:0]) : int'(b[N-2:0]);
    o  = 1'b0;
    case (op)
      2'b00:   r = va + vb;
      2'b01:   r = va - vb;
      2'b10:   r = mdl_acc + va;
      default: r = mdl_acc;
    endcase
    if (r > MAXM) begin r = MAXM; o = 1'b1; end
    else if (r < -MAXM) begin r = -MAXM; o = 1'b1; end
    if (op == 2'b10) mdl_acc = r;
    if (op == 2'b11) mdl_acc = 0;
    return (r < 0) ? {o, 1'b1, (N-1)'(-r)} : {o, 1'b0, (N-1)'(r)};
  endfunction

  // Present one op, wait (bounded) for acceptance, queue its expected {ovf,sum}
  task automatic send(input string tag, input logic [1:0] op, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [N:0] e);
    int n;
    exp_t x;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({tag, "_accept_timeout"}, 32'(in_ready), 1);
    else begin
      x.tag = tag; x.v = e;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious", 32'(out_valid), 0);
      else begin
        x = exp_q.pop_front();
        chk(x.tag, 32'({out_ovf, out_sum}), 32'(x.v));
      end
      chk("negzero", 32'(out_sum == {1'b1, {(N-1){1'b0}}}), 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [1:0]   d_op [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  logic [N-1:0] d_a  [5] = '{8'h05, 8'h05, 8'h83, 8'h09, 8'h80};
  logic [N-1:0] d_b  [5] = '{8'h83, 8'h83, 8'h83, 8'h89, 8'h80};
  logic [N:0]   d_e  [5] = '{9'h002, 9'h008, 9'h000, 9'h000, 9'h000};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'({out_ovf, out_sum}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // add/sub with latency: S1 after accept edge, output after the next edge
    for (int i = 0; i < 5; i++) begin
      send($sformatf("addsub%0d", i), d_op[i], d_a[i], d_b[i], d_e[i]);
      chk("lat_s1", 32'(out_valid), 0);
      @(posedge clk); #1;
      chk("lat_out", 32'({out_valid, out_ovf, out_sum}), 32'({1'b1, d_e[i]}));
      @(posedge clk); #1;
    end

    send("ovf_pos", 2'b00, 8'h64, 8'h32, 9'h17F);
    send("ovf_neg", 2'b00, 8'hE4, 8'hB2, 9'h1FF);
    send("ovf_none", 2'b00, 8'h7F, 8'hFF, 9'h000);
    drain();

    send("acc0", 2'b10, 8'h0A, 8'h00, 9'h00A);
    send("acc1", 2'b10, 8'h84, 8'h55, 9'h006);
    send("acc2", 2'b10, 8'h94, 8'h00, 9'h08E);
    send("rdclr", 2'b11, 8'h00, 8'h00, 9'h08E);
    send("acc3", 2'b10, 8'h01, 8'h00, 9'h001);
    drain();

    // backpressure: two ops fill the unit, then inputs stall until out_ready returns
    out_ready = 1'b0;
    send("bp0", 2'b00, 8'h10, 8'h05, 9'h015);
    send("bp1", 2'b01, 8'h03, 8'h07, 9'h084);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_head", 32'({out_valid, out_ovf, out_sum}), 32'({1'b1, 9'h015}));
    fork
      begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("bp_hold", 32'({out_valid, out_ovf, out_sum}), 32'({1'b1, 9'h015}));
          chk("bp_stall", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
      end
      begin
        send("bp2", 2'b00, 8'h81, 8'h81, 9'h082);
        send("bp3", 2'b01, 8'h7F, 8'h81, 9'h17F);
      end
    join
    drain();

    // reset with two ops in flight; acc was 0x01 before
    out_ready = 1'b0;
    send("rst_fl0", 2'b10, 8'h05, 8'h00, 9'h006);
    send("rst_fl1", 2'b10, 8'h05, 8'h00, 9'h00B);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    mdl_acc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_stale", 32'(out_valid), 0);
    end
    send("acc_cleared", 2'b11, 8'h00, 8'h00, 9'h000);
    drain();

    // random ops against the scoreboard model
    fork
      while (!rnd_done) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(3) != 0);
      end
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [1:0]   op;
          logic [N-1:0] a, b;
          op = 2'($urandom_range(3));
          a  = N'($urandom);
          b  = N'($urandom);
          if ($urandom_range(7) == 0) begin
            @(posedge clk); #1;
          end
          send("rand", op, a, b, model(op, a, b));
        end
        rnd_done = 1;
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
